cnt_timer_arb: RTL and testbench

//  Shares one loadable down-counter between NREQ requesters using round-robin arbitration.

---
 rtl/cnt_arb_pkg.sv | 32 +++
 rtl/load_dn_cnt.sv | 30 +++
 rtl/cnt_timer_arb.sv | 132 +++++++++++++
 tb/tb_cnt_timer_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_arb_pkg.sv
// Shared types and helpers for the round-robin counter/timer arbiter.
// Used by cnt_timer_arb and load_dn_cnt (optional abort path: CNT_ARB_ABORT_EN).
package cnt_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned CNT_ONE = 1;
   localparam int unsigned RR_MAX  = 32;

   // One-hot winner: first set req bit scanning upward from (ptr+1) mod nreq, with wrap.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input int unsigned       ptr,
                                                 input int unsigned       nreq);
      logic [RR_MAX-1:0] win;
      logic              found;
      int unsigned       idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX; k++) begin
         idx = (ptr + k) % nreq;
         if (!found && (k <= nreq) && req[idx[4:0]]) begin
            win[idx[4:0]] = 1'b1;
            found         = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/load_dn_cnt.sv
// Loadable down-counter shared by all requesters; saturates at 1 when decrementing.
// Loading zero is how the owner clears it between intervals.
module load_dn_cnt
   import cnt_arb_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   output logic [N-1:0] q,
   output logic         is_one
);

   assign is_one = (q == N'(CNT_ONE));

   // Decrement never goes below 1 and never wraps from 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en && !is_one && (q != '0)) begin
         q <= q - N'(1);
      end
   end

endmodule

// File: rtl/cnt_timer_arb.sv
// Round-robin arbiter granting exclusive timed windows on one shared down-counter.
// Define CNT_ARB_ABORT_EN to add the abort/aborted ports for early interval termination.
module cnt_timer_arb
   import cnt_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned N    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] dur,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [N-1:0]      cnt_q
`ifdef CNT_ARB_ABORT_EN
   ,
   input  logic              abort,
   output logic              aborted
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t            state, state_d;
   logic [PW-1:0]     ptr, ptr_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [NREQ-1:0]   win;
   logic [PW-1:0]     w_idx;
   logic [N-1:0]      dw;
   logic [N-1:0]      eff;
   logic              cnt_load;
   logic [N-1:0]      cnt_val;
   logic              cnt_en;
   logic              cnt_is_one;
   logic              abort_s;

`ifdef CNT_ARB_ABORT_EN
   assign abort_s = abort;
   // Completion wins over abort when both land in the last cycle.
   assign aborted = (state == RUN) && abort && !cnt_is_one;
`else
   assign abort_s = 1'b0;
`endif

   load_dn_cnt #(.N(N)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .q        (cnt_q),
      .is_one   (cnt_is_one)
   );

   // Winner selection and its effective duration (zero means one cycle).
   always_comb begin
      win   = NREQ'(rr_pick(RR_MAX'(req), 32'(ptr), NREQ));
      w_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            w_idx = PW'(i);
         end
      end
      dw  = dur[w_idx*N +: N];
      eff = (dw == '0) ? N'(CNT_ONE) : dw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= PW'(NREQ - 1);
         grant_q <= '0;
         done_q  <= '0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         grant_q <= grant_d;
         done_q  <= done_d;
      end
   end

   // done is registered one cycle early so it coincides with cnt_q==1.
   always_comb begin
      state_d  = state;
      ptr_d    = ptr;
      grant_d  = grant_q;
      done_d   = '0;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_en   = 1'b0;
      case (state)
         IDLE: begin
            grant_d = '0;
            if (req != '0) begin
               state_d  = RUN;
               ptr_d    = w_idx;
               grant_d  = win;
               cnt_load = 1'b1;
               cnt_val  = eff;
               if (eff == N'(CNT_ONE)) begin
                  done_d = win;
               end
            end
         end
         RUN: begin
            if (cnt_is_one || abort_s) begin
               state_d  = IDLE;
               grant_d  = '0;
               cnt_load = 1'b1;
               cnt_val  = '0;
            end else begin
               cnt_en = 1'b1;
               if (cnt_q == N'(2)) begin
                  done_d = grant_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state == RUN);

endmodule

// File: tb/tb_cnt_timer_arb.sv
// Self-checking bench for cnt_timer_arb: directed vector table, corner sequences,
// and randomized traffic against an interval-level reference model.
module tb_cnt_timer_arb;

   localparam int NREQ = 4;
   localparam int N    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] dur;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [N-1:0]      cnt_q;
`ifdef CNT_ARB_ABORT_EN
   logic              abort;
   logic              aborted;
   logic              pre_aborted;
`endif
   logic [NREQ-1:0]   pre_done;

   int checks = 0;
   int errors = 0;

   // Model state: remaining cycles of the current interval (0 = idle), owner, rr pointer.
   int m_rem   = 0;
   int m_owner = 0;
   int m_ptr   = NREQ - 1;

   always #5 clk = ~clk;

   cnt_timer_arb #(.NREQ(NREQ), .N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .dur     (dur),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .cnt_q   (cnt_q)
`ifdef CNT_ARB_ABORT_EN
      ,
      .abort   (abort),
      .aborted (aborted)
`endif
   );

   typedef struct {
      logic              rst;
      logic [NREQ-1:0]   req;
      logic [NREQ*N-1:0] dur;
      logic [NREQ-1:0]   g;
      logic [NREQ-1:0]   d;
      logic              b;
      logic [N-1:0]      c;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [31:0] d,
                               input logic [3:0] g, input logic [3:0] dn, input logic b,
                               input logic [7:0] c);
      vec_t v;
      v.rst = r; v.req = q; v.dur = d; v.g = g; v.d = dn; v.b = b; v.c = c;
      return v;
   endfunction

   function automatic int m_grant();
      return (m_rem > 0) ? (1 << m_owner) : 0;
   endfunction

   function automatic int m_done();
      return (m_rem == 1) ? (1 << m_owner) : 0;
   endfunction

   // Advance the model across one clock edge.
   task automatic model_step(input logic r, input logic [NREQ-1:0] q,
                             input logic [NREQ*N-1:0] d, input logic a);
      int idx;
      int dv;
      if (r) begin
         m_rem = 0;
         m_ptr = NREQ - 1;
      end else if (m_rem == 0) begin
         if (q != '0) begin
            for (int k = NREQ; k >= 1; k--) begin
               idx = (m_ptr + k) % NREQ;
               if (q[idx]) m_owner = idx;
            end
            m_ptr = m_owner;
            dv    = int'(d[m_owner*N +: N]);
            m_rem = (dv == 0) ? 1 : dv;
         end
      end else if (a && m_rem != 1) begin
         m_rem = 0;
      end else begin
         m_rem = m_rem - 1;
      end
   endtask

   // Drive one cycle of inputs, check in-cycle outputs, then check post-edge state.
   task automatic cycle(input logic r, input logic [NREQ-1:0] q,
                        input logic [NREQ*N-1:0] d, input logic a);
      rst = r; req = q; dur = d;
`ifdef CNT_ARB_ABORT_EN
      abort = a;
      #1;
      pre_aborted = aborted;
      chk("aborted", int'(aborted), (m_rem > 1 && a) ? 1 : 0);
`else
      #1;
`endif
      pre_done = done;
      @(posedge clk);
      model_step(r, q, d, a);
      #1;
      chk("grant", int'(grant), m_grant());
      chk("done",  int'(done),  m_done());
      chk("busy",  int'(busy),  (m_rem > 0) ? 1 : 0);
      chk("cnt_q", int'(cnt_q), m_rem);
   endtask

   initial begin
      int gcount;
      logic [NREQ-1:0]   rq;
      logic [NREQ*N-1:0] rd;
      logic              ra;
      logic              rr;

      rst = 1'b1; req = '0; dur = '0;
`ifdef CNT_ARB_ABORT_EN
      abort = 1'b0;
`endif

      // Reset with all requests, then round-robin over all four with dur=2.
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'b1111, 32'h02020202, 0, 0, 0, 0));
      for (int c = 0; c < 5; c++) begin
         vecs.push_back(mk(0, 4'b1111, 32'h02020202, 4'(1 << (c % 4)), 0, 1, 2));
         vecs.push_back(mk(0, 4'b1111, 32'h02020202, 4'(1 << (c % 4)), 4'(1 << (c % 4)), 1, 1));
         if (c < 4) vecs.push_back(mk(0, 4'b1111, 32'h02020202, 0, 0, 0, 0));
      end
      vecs.push_back(mk(0, 4'b0000, 32'h02020202, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0000, 32'h02020202, 0, 0, 0, 0));
      // Single client 1 with dur=5.
      vecs.push_back(mk(0, 4'b0010, 32'h00000500, 4'b0010, 0, 1, 5));
      vecs.push_back(mk(0, 4'b0000, 32'h00000500, 4'b0010, 0, 1, 4));
      vecs.push_back(mk(0, 4'b0000, 32'h00000500, 4'b0010, 0, 1, 3));
      vecs.push_back(mk(0, 4'b0000, 32'h00000500, 4'b0010, 0, 1, 2));
      vecs.push_back(mk(0, 4'b0000, 32'h00000500, 4'b0010, 4'b0010, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 32'h00000500, 0, 0, 0, 0));
      // dur=0 behaves as one cycle with done in that cycle.
      vecs.push_back(mk(0, 4'b0100, 32'h00000000, 4'b0100, 4'b0100, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 32'h00000000, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; req = vecs[i].req; dur = vecs[i].dur;
         @(posedge clk);
         model_step(vecs[i].rst, vecs[i].req, vecs[i].dur, 1'b0);
         #1;
         chk($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].g));
         chk($sformatf("vec%0d_done", i),  int'(done),  int'(vecs[i].d));
         chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(vecs[i].b));
         chk($sformatf("vec%0d_cnt", i),   int'(cnt_q), int'(vecs[i].c));
      end

      // Maximum duration: exactly 255 grant cycles, no wrap.
      gcount = 0;
      for (int i = 0; i < 300; i++) begin
         cycle(0, (i == 0) ? 4'b0001 : 4'b0000, 32'h000000FF, 0);
         if (grant == 4'b0001) gcount++;
      end
      chk("ff_len", gcount, 255);

      // Owner drops its request mid-interval: window still runs 10 cycles.
      gcount = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(0, (i < 3) ? 4'b0100 : 4'b0000, 32'h000A0000, 0);
         if (grant == 4'b0100) gcount++;
      end
      chk("drop_len", gcount, 10);

      // Client 3 raised during client 0's window wins next in rr order.
      cycle(0, 4'b0001, 32'h02000003, 0);
      chk("rr_first", int'(grant), 4'b0001);
      for (int i = 0; i < 4; i++) cycle(0, 4'b1001, 32'h02000003, 0);
      chk("rr_next", int'(grant), 4'b1000);
      for (int i = 0; i < 4; i++) cycle(0, 4'b0000, 32'h02000003, 0);

      // Reset in RUN: silent abort, pointer back to NREQ-1.
      cycle(0, 4'b0010, 32'h00000800, 0);
      cycle(0, 4'b0000, 32'h00000800, 0);
      cycle(0, 4'b0000, 32'h00000800, 0);
      cycle(1, 4'b0000, 32'h00000800, 0);
      chk("rst_grant", int'(grant), 0);
      chk("rst_done",  int'(done),  0);
      chk("rst_cnt",   int'(cnt_q), 0);
      cycle(0, 4'b1111, 32'h01010101, 0);
      chk("rst_ptr", int'(grant), 4'b0001);
      cycle(0, 4'b0000, 32'h01010101, 0);

`ifdef CNT_ARB_ABORT_EN
      // Abort in the third cycle of a 10-cycle window.
      cycle(0, 4'b0001, 32'h0000000A, 0);
      cycle(0, 4'b0000, 32'h0000000A, 0);
      cycle(0, 4'b0000, 32'h0000000A, 0);
      chk("ab_cnt3", int'(cnt_q), 8);
      cycle(0, 4'b0000, 32'h0000000A, 1);
      chk("ab_pulse", int'(pre_aborted), 1);
      chk("ab_nodone", int'(pre_done), 0);
      chk("ab_grant_low", int'(grant), 0);
      // Abort coincident with the last cycle counts as completion.
      cycle(0, 4'b0001, 32'h00000002, 0);
      cycle(0, 4'b0000, 32'h00000002, 0);
      cycle(0, 4'b0000, 32'h00000002, 1);
      chk("abl_done", int'(pre_done), 4'b0001);
      chk("abl_aborted", int'(pre_aborted), 0);
`endif

      // Randomized traffic against the model.
      cycle(1, '0, '0, 0);
      cycle(1, '0, '0, 0);
      rq = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom);
         for (int c = 0; c < NREQ; c++) begin
            rd[c*N +: N] = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 40))
                                                       : N'($urandom_range(0, 5));
         end
`ifdef CNT_ARB_ABORT_EN
         ra = ($urandom_range(0, 15) == 0);
`else
         ra = 1'b0;
`endif
         rr = ($urandom_range(0, 199) == 0);
         cycle(rr, rq, rd, ra);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
